// File: rtl/vga_plot_scheduler.sv
// vga_plot_scheduler
//   Frame sequencer and plot-port arbiter that sits in front of vga_adapter.
//   Each frame-rate tick starts a frame. With VGA_SCHED_CLEAR_EN defined, the
//   frame begins with a BG_COLOUR sweep of the whole X_MAX x Y_MAX buffer. After
//   the optional sweep, frame_start pulses and the port is shared round-robin
//   between the raycast scene (req0) and the HUD/minimap overlay (req1).
//   The frame ends once both requesters have reported done.
//   Optional feature macro: VGA_SCHED_CLEAR_EN (undefined = no clear sweep).
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   frame_clk             slow frame-rate square wave (asynchronous to clock)
//   frame_start           one-cycle pulse on entry to the drawing phase
//   busy                  high from frame accept until both drawers are done
//   overrun               one-cycle pulse when a tick arrives while busy
//   reqN_valid/x/y/colour pixel request from drawer N (N = 0, 1)
//   reqN_ready            grant (combinational); transfer on valid & ready
//   reqN_done             one-cycle pulse: drawer N finished its frame
//   x, y, colour, plot    registered plot port towards vga_adapter

module vga_plot_scheduler #(
    parameter int unsigned X_MAX = 160,
    parameter int unsigned Y_MAX = 120,
    parameter int unsigned XW    = 8,
    parameter int unsigned YW    = 7,
    parameter int unsigned CW    = 3
`ifdef VGA_SCHED_CLEAR_EN
    ,
    parameter logic [CW-1:0] BG_COLOUR = '0
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          frame_clk,
    output logic          frame_start,
    output logic          busy,
    output logic          overrun,

    input  logic          req0_valid,
    input  logic [XW-1:0] req0_x,
    input  logic [YW-1:0] req0_y,
    input  logic [CW-1:0] req0_colour,
    output logic          req0_ready,
    input  logic          req0_done,

    input  logic          req1_valid,
    input  logic [XW-1:0] req1_x,
    input  logic [YW-1:0] req1_y,
    input  logic [CW-1:0] req1_colour,
    output logic          req1_ready,
    input  logic          req1_done,

    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot
);

`ifdef VGA_SCHED_CLEAR_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd2
    } state_t;
`endif

    state_t        state;
    state_t        next_state;
    logic          frame_start_next;

    logic [2:0]    sync;
    logic          tick;

    logic [1:0]    done_flags;
    logic [1:0]    flags_upd;
    logic          last_grant;

    logic          in_draw;
    logic          xfer0;
    logic          xfer1;
    logic          pix_valid;
    logic          pix_in_range;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [CW-1:0] pix_colour;

    // Two-flop synchroniser, third flop for edge history; tick is registered
    // so it lands three cycles after the frame_clk edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            tick <= sync[1] & ~sync[2];
        end
    end

    // Round-robin grant: on contention the requester not served last wins.
    assign in_draw    = (state == DRAW);
    assign req0_ready = in_draw & req0_valid & (~req1_valid | last_grant);
    assign req1_ready = in_draw & req1_valid & (~req0_valid | ~last_grant);
    assign xfer0      = req0_valid & req0_ready;
    assign xfer1      = req1_valid & req1_ready;

    assign pix_valid    = xfer0 | xfer1;
    assign pix_x        = xfer1 ? req1_x      : req0_x;
    assign pix_y        = xfer1 ? req1_y      : req0_y;
    assign pix_colour   = xfer1 ? req1_colour : req0_colour;
    assign pix_in_range = (pix_x < XW'(X_MAX)) && (pix_y < YW'(Y_MAX));

    // A tick outside IDLE is dropped and flagged in the same cycle.
    assign overrun = tick & (state != IDLE);

    // Done pulses seen this cycle count towards the frame-complete decision.
    assign flags_upd = done_flags | {req1_done, req0_done};

`ifdef VGA_SCHED_CLEAR_EN
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          sweep_last;

    assign sweep_last = (cx == XW'(X_MAX - 1)) && (cy == YW'(Y_MAX - 1));

    // Raster sweep counters: x inner, y outer; parked at (0,0) outside CLEAR.
    always_ff @(posedge clock) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (state == CLEAR) begin
            if (cx == XW'(X_MAX - 1)) begin
                cx <= '0;
                cy <= (cy == YW'(Y_MAX - 1)) ? '0 : cy + YW'(1);
            end else begin
                cx <= cx + XW'(1);
            end
        end else begin
            cx <= '0;
            cy <= '0;
        end
    end
`endif

    // Next-state logic.
    always_comb begin
        next_state       = state;
        frame_start_next = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
`ifdef VGA_SCHED_CLEAR_EN
                    next_state = CLEAR;
`else
                    next_state       = DRAW;
                    frame_start_next = 1'b1;
`endif
                end
            end
`ifdef VGA_SCHED_CLEAR_EN
            CLEAR: begin
                if (sweep_last) begin
                    next_state       = DRAW;
                    frame_start_next = 1'b1;
                end
            end
`endif
            DRAW: begin
                if (&flags_upd) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus registered frame status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= next_state;
            busy        <= (next_state != IDLE);
            frame_start <= frame_start_next;
        end
    end

    // Sticky done flags: cleared on frame accept, collected only while drawing.
    always_ff @(posedge clock) begin
        if (reset) begin
            done_flags <= '0;
        end else if ((state == IDLE) && tick) begin
            done_flags <= '0;
        end else if (in_draw) begin
            done_flags <= flags_upd;
        end
    end

    // Remember who was served last; starts at 1 so req0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (xfer0) begin
            last_grant <= 1'b0;
        end else if (xfer1) begin
            last_grant <= 1'b1;
        end
    end

    // Plot port: one-cycle latency; coordinates hold when nothing is plotted.
    always_ff @(posedge clock) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
        end else begin
            plot <= 1'b0;
`ifdef VGA_SCHED_CLEAR_EN
            if (state == CLEAR) begin
                x      <= cx;
                y      <= cy;
                colour <= BG_COLOUR;
                plot   <= 1'b1;
            end else
`endif
            if (pix_valid && pix_in_range) begin
                x      <= pix_x;
                y      <= pix_y;
                colour <= pix_colour;
                plot   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// tb_vga_plot_scheduler
//   Directed bench for vga_plot_scheduler: reset state, tick latency, optional
//   clear sweep, round-robin arbitration, out-of-range drops, done/overrun
//   handling and mid-frame reset. Adapts to VGA_SCHED_CLEAR_EN.
`timescale 1ns/1ps

module tb_vga_plot_scheduler;

    logic       clock;
    logic       reset;
    logic       frame_clk;
    logic       frame_start;
    logic       busy;
    logic       overrun;
    logic       req0_valid;
    logic [7:0] req0_x;
    logic [6:0] req0_y;
    logic [2:0] req0_colour;
    logic       req0_ready;
    logic       req0_done;
    logic       req1_valid;
    logic [7:0] req1_x;
    logic [6:0] req1_y;
    logic [2:0] req1_colour;
    logic       req1_ready;
    logic       req1_done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_vec = 0;
    int n_err = 0;

    vga_plot_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .frame_clk   (frame_clk),
        .frame_start (frame_start),
        .busy        (busy),
        .overrun     (overrun),
        .req0_valid  (req0_valid),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_colour (req0_colour),
        .req0_ready  (req0_ready),
        .req0_done   (req0_done),
        .req1_valid  (req1_valid),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_colour (req1_colour),
        .req1_ready  (req1_ready),
        .req1_done   (req1_done),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Let combinational ready settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // Raise frame_clk and follow the frame into its drawing phase. Returns at
    // the sample point of the first DRAW cycle (frame_start high).
    task automatic start_frame();
        int cnt;
        int seen;
        logic [7:0] fx, lx;
        logic [6:0] fy, ly;
        logic [2:0] fc, lc;
        frame_clk = 1'b1;
        step();
        step();
        check("busy_before_tick", 32'(busy), 32'd0);
        step();
        check("overrun_on_idle_tick", 32'(overrun), 32'd0);
        check("busy_on_tick_cycle", 32'(busy), 32'd0);
        step();
        frame_clk = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
`ifdef VGA_SCHED_CLEAR_EN
        check("fs_low_in_clear", 32'(frame_start), 32'd0);
        check("plot_low_first_clear", 32'(plot), 32'd0);
        cnt = 0; seen = 0;
        fx = '1; fy = '1; fc = '1; lx = '0; ly = '0; lc = '1;
        for (int i = 0; i < 19300; i++) begin
            step();
            if (plot) begin
                if (cnt == 0) begin
                    fx = x; fy = y; fc = colour;
                end
                cnt++;
                lx = x; ly = y; lc = colour;
            end
            if (frame_start) begin
                seen = 1;
                break;
            end
        end
        check("clear_fs_seen", 32'(seen), 32'd1);
        check("clear_plot_count", 32'(cnt), 32'd19200);
        check("clear_first_x", 32'(fx), 32'd0);
        check("clear_first_y", 32'(fy), 32'd0);
        check("clear_first_colour", 32'(fc), 32'd0);
        check("clear_last_x", 32'(lx), 32'd159);
        check("clear_last_y", 32'(ly), 32'd119);
        check("clear_last_colour", 32'(lc), 32'd0);
`else
        check("fs_on_draw_entry", 32'(frame_start), 32'd1);
`endif
    endtask

    initial begin
        reset       = 1'b1;
        frame_clk   = 1'b0;
        req0_valid  = 1'b1; req0_x = 8'd10; req0_y = 7'd20; req0_colour = 3'b100;
        req1_valid  = 1'b1; req1_x = 8'd5;  req1_y = 7'd5;  req1_colour = 3'b010;
        req0_done   = 1'b0;
        req1_done   = 1'b0;

        // Reset held two cycles with requests pending.
        step();
        step();
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Frame 1.
        start_frame();
        step();
        check("fs_one_cycle", 32'(frame_start), 32'd0);

        // Both requesting: req0 first (reset last_grant = 1), then alternate.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("arb_ready0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("arb_ready1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
            check("arb_plot", 32'(plot), 32'd1);
            check("arb_x", 32'(x), (i % 2 == 0) ? 32'd10 : 32'd5);
            check("arb_y", 32'(y), (i % 2 == 0) ? 32'd20 : 32'd5);
            check("arb_colour", 32'(colour), (i % 2 == 0) ? 32'd4 : 32'd2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        check("noreq_ready0", 32'(req0_ready), 32'd0);
        check("noreq_ready1", 32'(req1_ready), 32'd0);
        step();
        check("noreq_plot", 32'(plot), 32'd0);
        check("noreq_x_hold", 32'(x), 32'd5);
        check("noreq_colour_hold", 32'(colour), 32'd2);

        // Lone req1 is granted even though it was served last.
        req1_valid = 1'b1; req1_x = 8'd7; req1_y = 7'd8; req1_colour = 3'b011;
        settle();
        check("single1_ready1", 32'(req1_ready), 32'd1);
        check("single1_ready0", 32'(req0_ready), 32'd0);
        step();
        req1_valid = 1'b0;
        check("single1_plot", 32'(plot), 32'd1);
        check("single1_x", 32'(x), 32'd7);
        check("single1_y", 32'(y), 32'd8);

        // Out-of-range pixels are accepted but not plotted.
        req0_valid = 1'b1; req0_x = 8'd160; req0_y = 7'd0; req0_colour = 3'b101;
        settle();
        check("oor_x_ready", 32'(req0_ready), 32'd1);
        step();
        check("oor_x_plot", 32'(plot), 32'd0);
        check("oor_x_hold", 32'(x), 32'd7);
        req0_x = 8'd0; req0_y = 7'd120;
        settle();
        check("oor_y_ready", 32'(req0_ready), 32'd1);
        step();
        check("oor_y_plot", 32'(plot), 32'd0);
        check("oor_y_hold", 32'(y), 32'd8);
        req0_x = 8'd159; req0_y = 7'd119;
        step();
        check("edge_plot", 32'(plot), 32'd1);
        check("edge_x", 32'(x), 32'd159);
        check("edge_y", 32'(y), 32'd119);
        check("edge_colour", 32'(colour), 32'd5);

        // done0 together with a transfer: the pixel still goes out.
        req0_x = 8'd20; req0_y = 7'd30; req0_colour = 3'b001;
        req0_done = 1'b1;
        step();
        req0_done  = 1'b0;
        req0_valid = 1'b0;
        check("done0_xfer_plot", 32'(plot), 32'd1);
        check("done0_xfer_x", 32'(x), 32'd20);
        check("done0_busy", 32'(busy), 32'd1);

        // Extra frame_clk edge while drawing: overrun only.
        frame_clk = 1'b1;
        step();
        step();
        check("ovr_before", 32'(overrun), 32'd0);
        step();
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_busy", 32'(busy), 32'd1);
        step();
        check("ovr_after", 32'(overrun), 32'd0);
        check("ovr_no_fs", 32'(frame_start), 32'd0);
        check("ovr_still_busy", 32'(busy), 32'd1);
        frame_clk = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("ovr_no_plot", 32'(plot), 32'd0);

        // done1 completes the frame.
        req1_done = 1'b1;
        step();
        req1_done = 1'b0;
        check("done1_busy_fall", 32'(busy), 32'd0);
        req0_valid = 1'b1;
        settle();
        check("idle_ready0", 32'(req0_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        check("idle_no_plot", 32'(plot), 32'd0);

        // Frame 2: flags from frame 1 must not carry over.
        start_frame();
        step();
        req1_done = 1'b1;
        step();
        req1_done = 1'b0;
        check("f2_done1_only_busy", 32'(busy), 32'd1);
        req0_done = 1'b1;
        step();
        req0_done = 1'b0;
        check("f2_done0_busy_fall", 32'(busy), 32'd0);
        step();

        // Mid-frame reset.
`ifdef VGA_SCHED_CLEAR_EN
        begin
            int pix;
            frame_clk = 1'b1;
            for (int i = 0; i < 4; i++) step();
            frame_clk = 1'b0;
            pix = 0;
            for (int i = 0; i < 600; i++) begin
                step();
                if (plot) pix++;
                if (pix == 500) break;
            end
            check("mid_clear_reached", 32'(pix), 32'd500);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            reset = 1'b1;
            step();
            check("midrst_plot", 32'(plot), 32'd0);
            check("midrst_busy", 32'(busy), 32'd0);
        end
`else
        start_frame();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        settle();
        // last transfer in frame 1 was req0, so req1 wins this tie
        check("f3_ready1", 32'(req1_ready), 32'd1);
        check("f3_ready0", 32'(req0_ready), 32'd0);
        reset = 1'b1;
        step();
        check("midrst_plot", 32'(plot), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
`endif
        settle();
        check("midrst_ready0", 32'(req0_ready), 32'd0);
        check("midrst_ready1", 32'(req1_ready), 32'd0);
        reset      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_x = 8'd10; req0_y = 7'd20; req0_colour = 3'b100;
        req1_x = 8'd5;  req1_y = 7'd5;  req1_colour = 3'b010;
        step();
        check("postrst_plot", 32'(plot), 32'd0);

        // Next tick restarts cleanly; arbitration back to req0 first.
        start_frame();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        settle();
        check("postrst_ready0", 32'(req0_ready), 32'd1);
        check("postrst_ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("postrst_arb_plot", 32'(plot), 32'd1);
        check("postrst_arb_x", 32'(x), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
